// File: rtl/tile_data_mem.sv
// tile_data_mem: per-tile data memory responder for one CGRA tile.
// Stores and loads enter a small in-order request queue. The head entry
// executes against a 1024x32 array at one entry per cycle. Load data
// returns through a single response register, tagged with the
// destination register.
// Optional feature macro: DMEM_COUNTERS_EN adds saturating 16-bit counters
// (wr_count, rd_count) for executed stores and loads.
module tile_data_mem #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int TAG_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] recv_from_memory_data,
    output logic [TAG_W-1:0]  recv_from_memory_addr
`ifdef DMEM_COUNTERS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Request queue storage: one field array per entry component.
    logic              q_write [FIFO_DEPTH];
    logic [ADDR_W-1:0] q_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] q_data  [FIFO_DEPTH];
    logic [TAG_W-1:0]  q_tag   [FIFO_DEPTH];

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] rd_slot;
    logic [CNT_W-1:0] count;

    logic push_wr;
    logic push_rd;
    logic head_valid;
    logic exec_store;
    logic exec_load;
    logic pop;

    // Readiness comes only from the registered count, so a dequeue
    // frees its slot for new requests one cycle later. A load needs one
    // extra free slot when a store arrives alongside it.
    assign wr_ready = (count < CNT_W'(FIFO_DEPTH));
    assign rd_ready = (({1'b0, count} + {{CNT_W{1'b0}}, wr_valid}) < (CNT_W+1)'(FIFO_DEPTH));

    assign push_wr = wr_valid && wr_ready;
    assign push_rd = rd_valid && rd_ready;
    assign rd_slot = tail + PTR_W'(push_wr);

    // A store at the head always completes. A load completes only when
    // the response register is empty or is drained in this same cycle.
    assign head_valid = (count != '0);
    assign exec_store = head_valid && q_write[head];
    assign exec_load  = head_valid && !q_write[head] && (!resp_valid || resp_ready);
    assign pop        = exec_store || exec_load;

    // Queue payload write; the store takes the tail slot ahead of the load.
    always_ff @(posedge clk) begin
        if (push_wr) begin
            q_write[tail] <= 1'b1;
            q_addr[tail]  <= wr_addr;
            q_data[tail]  <= wr_data;
            q_tag[tail]   <= '0;
        end
        if (push_rd) begin
            q_write[rd_slot] <= 1'b0;
            q_addr[rd_slot]  <= rd_addr;
            q_tag[rd_slot]   <= rd_tag;
        end
    end

    // Queue pointers and occupancy; reset flushes every pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PTR_W'(push_wr) + PTR_W'(push_rd);
            head  <= head + PTR_W'(pop);
            count <= count + CNT_W'(push_wr) + CNT_W'(push_rd) - CNT_W'(pop);
        end
    end

    // Memory array writes; no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (exec_store) begin
            mem[q_addr[head]] <= q_data[head];
        end
    end

    // Response register: loads fill it, and consumption empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid            <= 1'b0;
            recv_from_memory_data <= '0;
            recv_from_memory_addr <= '0;
        end else if (exec_load) begin
            resp_valid            <= 1'b1;
            recv_from_memory_data <= mem[q_addr[head]];
            recv_from_memory_addr <= q_tag[head];
        end else if (resp_ready) begin
            resp_valid            <= 1'b0;
        end
    end

`ifdef DMEM_COUNTERS_EN
    // Saturating counts of executed stores and loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (exec_store && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (exec_load && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
